// File: rtl/pipectrl_stage.sv
// pipectrl_stage: one pipeline slot's control state (valid flag and tag).
// A load takes priority over an unload; an unload alone empties the slot and zeroes the tag,
// so an empty slot always reads back a zero tag.
module pipectrl_stage #(
  parameter int TAGWIDTH = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld,
  input  logic                unld,
  input  logic [TAGWIDTH-1:0] tag_in,
  output logic                valid,
  output logic [TAGWIDTH-1:0] tag_out
);

  // Slot state: load wins over unload, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      tag_out <= '0;
    end else if (ld) begin
      valid   <= 1'b1;
      tag_out <= tag_in;
    end else if (unld) begin
      valid   <= 1'b0;
      tag_out <= '0;
    end
  end

endmodule

// File: rtl/pipectrl.sv
// pipectrl: turns a src_rdy/dst_rdy stream into per-stage load strobes for a
// clock-enabled datapath, carrying a tag with each stage. Empty stages are filled
// even while the output stalls, so bubbles collapse.
// Optional feature: define PIPECTRL_OCC_EN to add the registered occupancy counter port.
module pipectrl #(
  parameter int STAGES   = 3,
  parameter int TAGWIDTH = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                src_rdy_i,
  output logic                dst_rdy_o,
  input  logic [TAGWIDTH-1:0] tag_i,
  output logic [STAGES-1:0]   stage_stb,
  output logic                src_rdy_o,
  input  logic                dst_rdy_i,
  output logic [TAGWIDTH-1:0] tag_o
`ifdef PIPECTRL_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

  logic                flush;
  logic [STAGES:0]     ready;
  logic [STAGES-1:0]   valid;
  logic [STAGES-1:0]   unld;
  logic [TAGWIDTH-1:0] tag [STAGES];

  assign flush = reset | clear;

  // Ready chain: stage k can take an item if it is empty or its item moves on this cycle.
  // Evaluated from the output end through a running variable so no vector bit feeds another.
  always_comb begin
    logic r;
    ready = '0;
    r = dst_rdy_i;
    ready[STAGES] = r;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r = ~valid[k] | r;
      ready[k] = r;
    end
  end

  // Load strobes (suppressed during flush) and per-stage unload conditions.
  always_comb begin
    stage_stb = '0;
    unld      = '0;
    for (int k = 0; k < STAGES; k++) begin
      unld[k] = valid[k] & ready[k+1];
    end
    if (!flush) begin
      stage_stb[0] = src_rdy_i & ready[0];
      for (int k = 1; k < STAGES; k++) begin
        stage_stb[k] = valid[k-1] & ready[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [TAGWIDTH-1:0] tag_src;
    if (k == 0) begin : g_first
      assign tag_src = tag_i;
    end else begin : g_rest
      assign tag_src = tag[k-1];
    end
    pipectrl_stage #(.TAGWIDTH(TAGWIDTH)) u_stage (
      .clk     (clk),
      .reset   (flush),
      .ld      (stage_stb[k]),
      .unld    (unld[k]),
      .tag_in  (tag_src),
      .valid   (valid[k]),
      .tag_out (tag[k])
    );
  end

  assign dst_rdy_o = ready[0];
  assign src_rdy_o = valid[STAGES-1];
  assign tag_o     = tag[STAGES-1];

`ifdef PIPECTRL_OCC_EN
  logic occ_inc;
  logic occ_dec;
  assign occ_inc = stage_stb[0];
  assign occ_dec = unld[STAGES-1];

  // Items in flight: +1 on accept, -1 on output unload, unchanged when both happen.
  always_ff @(posedge clk) begin
    if (flush) begin
      occupancy <= '0;
    end else if (occ_inc && !occ_dec) begin
      occupancy <= occupancy + 1'b1;
    end else if (occ_dec && !occ_inc) begin
      occupancy <= occupancy - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipectrl.sv
// tb_pipectrl: directed scenarios plus random traffic for pipectrl (STAGES=3, TAGWIDTH=4),
// compared against a slot-sweep reference model of the pipe.
module tb_pipectrl;

  localparam int S  = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          src_rdy_i;
  logic          dst_rdy_o;
  logic [TW-1:0] tag_i;
  logic [S-1:0]  stage_stb;
  logic          src_rdy_o;
  logic          dst_rdy_i;
  logic [TW-1:0] tag_o;
`ifdef PIPECTRL_OCC_EN
  logic [$clog2(S+1)-1:0] occupancy;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: slot contents (valid and tag) for each stage.
  logic          mv [S];
  logic [TW-1:0] mt [S];

  // Values seen during the most recent step, for directed checks.
  logic          obs_dr;
  logic          obs_src;
  logic [TW-1:0] obs_tag;
  logic [S-1:0]  obs_stb;

  pipectrl #(.STAGES(S), .TAGWIDTH(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .tag_i     (tag_i),
    .stage_stb (stage_stb),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i),
    .tag_o     (tag_o)
`ifdef PIPECTRL_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model mid-cycle,
  // then advance the model across the clock edge.
  task automatic step(input logic s, input logic [TW-1:0] tg, input logic d, input logic c);
    logic          nv [S];
    logic [TW-1:0] nt [S];
    logic [S-1:0]  estb;
    logic          edr;
    int            cnt;
    src_rdy_i = s;
    tag_i     = tg;
    dst_rdy_i = d;
    clear     = c;
    @(negedge clk);
    for (int k = 0; k < S; k++) begin
      nv[k] = mv[k];
      nt[k] = mt[k];
    end
    estb = '0;
    cnt  = 0;
    for (int k = 0; k < S; k++) cnt += int'(mv[k]);
    // The item at the output leaves if downstream takes it.
    if (mv[S-1] && d) begin
      nv[S-1] = 1'b0;
      nt[S-1] = '0;
    end
    // Sweep from the output end: each item advances into a slot left empty.
    for (int k = S - 2; k >= 0; k--) begin
      if (nv[k] && !nv[k+1]) begin
        nv[k+1]   = 1'b1;
        nt[k+1]   = nt[k];
        nv[k]     = 1'b0;
        nt[k]     = '0;
        estb[k+1] = 1'b1;
      end
    end
    edr = !nv[0];
    if (edr && s) begin
      nv[0]   = 1'b1;
      nt[0]   = tg;
      estb[0] = 1'b1;
    end
    if (c) begin
      estb = '0;
      for (int k = 0; k < S; k++) begin
        nv[k] = 1'b0;
        nt[k] = '0;
      end
    end
    obs_dr  = dst_rdy_o;
    obs_src = src_rdy_o;
    obs_tag = tag_o;
    obs_stb = stage_stb;
    chk("dst_rdy_o", 32'(dst_rdy_o), 32'(edr));
    chk("stage_stb", 32'(stage_stb), 32'(estb));
    chk("src_rdy_o", 32'(src_rdy_o), 32'(mv[S-1]));
    chk("tag_o",     32'(tag_o),     32'(mt[S-1]));
`ifdef PIPECTRL_OCC_EN
    chk("occupancy", 32'(occupancy), 32'(cnt));
`endif
    @(posedge clk);
    #1;
    for (int k = 0; k < S; k++) begin
      mv[k] = nv[k];
      mt[k] = nt[k];
    end
  endtask

  task automatic drain();
    for (int i = 0; i < S + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < S; k++) begin
      mv[k] = 1'b0;
      mt[k] = '0;
    end
    reset     = 1'b1;
    clear     = 1'b0;
    src_rdy_i = 1'b1;
    dst_rdy_i = 1'b0;
    tag_i     = 4'h9;

    // Reset held two cycles with a source offering data.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_dst_rdy_o", 32'(dst_rdy_o), 32'd1);
    chk("rst_stage_stb", 32'(stage_stb), 32'd0);
    chk("rst_src_rdy_o", 32'(src_rdy_o), 32'd0);
    chk("rst_tag_o",     32'(tag_o),     32'd0);
`ifdef PIPECTRL_OCC_EN
    chk("rst_occupancy", 32'(occupancy), 32'd0);
`endif
    reset = 1'b0;

    // Streaming: tags 1..5 back to back with no backpressure.
    for (int i = 0; i < 8; i++) begin
      step(i < 5, 4'(i + 1), 1'b1, 1'b0);
      if (i >= 3) chk("stream_tag", 32'(obs_tag), 32'(i - 2));
      if (i >= 3) chk("stream_src", 32'(obs_src), 32'd1);
      if (i >= 2 && i <= 4) chk("stream_stb", 32'(obs_stb), 32'b111);
    end
    drain();

    // Backpressure: fill with A,B,C then stall, then release for one cycle.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    chk("full_dst_rdy", 32'(obs_dr), 32'd0);
    chk("full_tag_A",   32'(obs_tag), 32'hA);
    chk("full_stb",     32'(obs_stb), 32'd0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    chk("full_tag_hold", 32'(obs_tag), 32'hA);
    step(1'b1, 4'hD, 1'b1, 1'b0);
    chk("release_dst_rdy", 32'(obs_dr), 32'd1);
    chk("release_stb",     32'(obs_stb), 32'b111);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("release_next_tag", 32'(obs_tag), 32'hB);
    drain();

    // Bubble collapse: a lone item walks to the end while the output is stalled.
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    chk("bubble_tag7",   32'(obs_tag), 32'h7);
    chk("bubble_dr",     32'(obs_dr),  32'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_stb1",   32'(obs_stb), 32'b010);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_dr_free", 32'(obs_dr), 32'd1);
    drain();

    // Flush: two items in flight, clear for one cycle.
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("flush_stb", 32'(obs_stb), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_src", 32'(obs_src), 32'd0);
    chk("flush_tag", 32'(obs_tag), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_src2", 32'(obs_src), 32'd0);

    // Occupancy: accept and unload together at two items, then fill and keep pushing.
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    chk("occ_swap_out", 32'(obs_tag), 32'h3);
`ifdef PIPECTRL_OCC_EN
    chk("occ_before_swap", 32'(occupancy), 32'd2);
`endif
    step(1'b1, 4'h6, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    chk("occ_full_dr", 32'(obs_dr), 32'd0);
`ifdef PIPECTRL_OCC_EN
    chk("occ_full", 32'(occupancy), 32'd3);
`endif
    drain();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
